// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and widths for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int TIMEOUT_DEF = 255;
  localparam int WAIT_W = 8;
  localparam int STALL_W = 16;
  localparam int REG_W = 5;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the instruction in ID
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Write_Register,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  output logic             load_use
);
  assign load_use = EX_MemRead && EX_Write_Register != '0 &&
                    (EX_Write_Register == ID_rs || EX_Write_Register == ID_rt);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: memory-wait FSM, stall counter and stall/flush priority mux
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [REG_W-1:0]   ID_rs,
  input  logic [REG_W-1:0]   ID_rt,
  input  logic               EX_MemRead,
  input  logic [REG_W-1:0]   EX_Write_Register,
  input  logic               EX_branch_taken,
  input  logic               ID_jump,
  input  logic               MEM_MemRead,
  input  logic               MEM_MemWrite,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               idex_stall,
  output logic               exmem_stall,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               memwb_flush,
  output logic               mem_err,
  output logic [STALL_W-1:0] stall_cycles
);
  localparam logic [WAIT_W-1:0] TO = WAIT_W'(TIMEOUT);
  state_t state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic mem_op, mem_stall, timed_out, load_use;
  hazard_detect u_hazard (
    .EX_MemRead        (EX_MemRead),
    .EX_Write_Register (EX_Write_Register),
    .ID_rs             (ID_rs),
    .ID_rt             (ID_rt),
    .load_use          (load_use)
  );
  assign mem_op    = MEM_MemRead | MEM_MemWrite;
  assign timed_out = state == BUSY && !mem_ready && wait_cnt == TO;
  // the completion or timeout cycle itself lets the pipeline advance
  assign mem_stall = state == BUSY ? !mem_ready && wait_cnt < TO : mem_op;
  always_ff @(posedge sysclk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (mem_op ? BUSY : IDLE)
                              : (mem_ready || timed_out ? IDLE : BUSY);
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      wait_cnt     <= state == IDLE ? '0 : (!mem_ready && !timed_out ? wait_cnt + WAIT_W'(1) : wait_cnt);
      mem_err      <= mem_err | timed_out;
      stall_cycles <= stall_cycles + STALL_W'(mem_stall && ~&stall_cycles);
    end
  // priority: memory stall > taken branch > load-use > jump
  always_comb begin
    mem_req     = state == BUSY || mem_op;
    pc_stall    = mem_stall || (!EX_branch_taken && load_use);
    ifid_stall  = mem_stall || (!EX_branch_taken && load_use);
    idex_stall  = mem_stall;
    exmem_stall = mem_stall;
    memwb_flush = mem_stall;
    ifid_flush  = !mem_stall && (EX_branch_taken || (!load_use && ID_jump));
    idex_flush  = !mem_stall && (EX_branch_taken || load_use);
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl against a behavioural access model
module tb_pipe_ctrl;
  localparam int TO = 4;
  logic sysclk = 1'b0, reset = 1'b1;
  logic [4:0] ID_rs, ID_rt, EX_Write_Register;
  logic EX_MemRead, EX_branch_taken, ID_jump, MEM_MemRead, MEM_MemWrite, mem_ready;
  logic mem_req, pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, memwb_flush, mem_err;
  logic [15:0] stall_cycles;
  typedef struct packed {
    logic [4:0] rs, rt, wr;
    logic exrd, br, jmp, mrd, mwr, rdy;
  } stim_t;
  typedef struct {
    logic [7:0]  o;
    logic        err;
    logic [15:0] sc;
  } exp_t;
  exp_t q[$];
  stim_t cur;
  bit m_busy, m_err;
  int m_waits, m_sc;
  int checks, fails;
  logic [15:0] sc0;
  always #5 sysclk = ~sysclk;
  pipe_ctrl #(.TIMEOUT(TO)) dut (
    .sysclk(sysclk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EX_MemRead(EX_MemRead), .EX_Write_Register(EX_Write_Register),
    .EX_branch_taken(EX_branch_taken), .ID_jump(ID_jump),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall), .exmem_stall(exmem_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_flush(memwb_flush), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );
  function automatic stim_t mk(int rs, int rt, int wr, bit exrd, bit br, bit jmp, bit mrd, bit mwr, bit rdy);
    return {5'(rs), 5'(rt), 5'(wr), exrd, br, jmp, mrd, mwr, rdy};
  endfunction
  function automatic void chk(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction
  // an access stalls on its detect cycle and on every unanswered wait below the limit
  function automatic bit m_stall();
    return m_busy ? (!cur.rdy && m_waits < TO) : (cur.mrd || cur.mwr);
  endfunction
  function automatic void model_clock();
    bit st = m_stall();
    if (st && m_sc < 65535) m_sc++;
    if (m_busy) begin
      if (cur.rdy) m_busy = 0;
      else if (m_waits == TO) begin m_busy = 0; m_err = 1; end
      else m_waits++;
    end else if (cur.mrd || cur.mwr) begin
      m_busy = 1;
      m_waits = 0;
    end
  endfunction
  function automatic void push();
    exp_t e;
    bit lu = cur.exrd && cur.wr != 0 && (cur.wr == cur.rs || cur.wr == cur.rt);
    logic [6:0] pat;
    pat = m_stall() ? 7'b1111001 : cur.br ? 7'b0000110 : lu ? 7'b1100010 :
          cur.jmp ? 7'b0000100 : 7'b0000000;
    e.o = {m_busy || cur.mrd || cur.mwr, pat};
    e.err = m_err;
    e.sc = 16'(m_sc);
    q.push_back(e);
  endfunction
  task automatic apply();
    {ID_rs, ID_rt, EX_Write_Register, EX_MemRead, EX_branch_taken, ID_jump,
     MEM_MemRead, MEM_MemWrite, mem_ready} = cur;
  endtask
  task automatic drive(input stim_t s);
    @(posedge sysclk); #1;
    if (reset) reset = 1'b0;
    else model_clock();
    cur = s;
    apply();
    push();
  endtask
  task automatic do_reset();
    @(posedge sysclk); #1;
    if (!reset) model_clock();
    #1 reset = 1'b1;
    cur = '0;
    apply();
    m_busy = 0; m_err = 0; m_waits = 0; m_sc = 0;
    push();
  endtask
  always @(negedge sysclk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({mem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush} !== e.o ||
          mem_err !== e.err || stall_cycles !== e.sc) begin
        fails++;
        $display("FAIL cycle @%0t: got req/stall/flush=%b err=%b sc=%0d expected %b err=%b sc=%0d",
                 $time, {mem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush},
                 mem_err, stall_cycles, e.o, e.err, e.sc);
      end
    end
  end
  initial begin
    cur = '0;
    apply();
    drive(mk(8, 0, 8, 1, 0, 0, 0, 0, 0)); #1 chk("load_use", 16'({pc_stall, ifid_stall, idex_flush, ifid_flush}), 16'hE);
    drive(mk(8, 0, 0, 1, 0, 0, 0, 0, 0)); #1 chk("load_use_r0", 16'({pc_stall, ifid_stall, idex_flush, ifid_flush}), 16'h0);
    drive(mk(3, 8, 8, 1, 1, 1, 0, 0, 0)); #1 chk("branch_over_lu", 16'({ifid_flush, idex_flush, pc_stall}), 16'h6);
    drive(mk(3, 8, 8, 1, 0, 1, 0, 0, 0)); #1 chk("lu_over_jump", 16'({ifid_flush, pc_stall}), 16'h1);
    drive('0);
    sc0 = stall_cycles;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 1)); #1 chk("load_done_nostall", 16'(pc_stall), 16'h0);
    drive('0); #1 chk("load_sc", stall_cycles - sc0, 16'd4);
    chk("load_idle_req", 16'(mem_req), 16'h0);
    sc0 = stall_cycles;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); #1 chk("st_req0", 16'(mem_req), 16'h1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); #1 chk("st_req1", 16'(mem_req), 16'h1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0)); #1 chk("ld_req0", 16'(mem_req), 16'h1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 1)); #1 chk("ld_req1", 16'(mem_req), 16'h1);
    drive('0); #1 chk("b2b_sc", stall_cycles - sc0, 16'd2);
    sc0 = stall_cycles;
    repeat (5) drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0)); #1 chk("timeout_release", 16'(exmem_stall), 16'h0);
    drive('0); #1 chk("timeout_sc", stall_cycles - sc0, 16'd5);
    chk("timeout_err", 16'(mem_err), 16'h1);
    repeat (3) drive('0);
    #1 chk("err_sticky", 16'(mem_err), 16'h1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    do_reset(); #1 chk("rst_req", 16'(mem_req), 16'h0);
    chk("rst_sc", stall_cycles, 16'h0);
    chk("rst_err", 16'(mem_err), 16'h0);
    drive('0); #1 chk("post_rst_stall", 16'({pc_stall, exmem_stall, memwb_flush}), 16'h0);
    repeat (3000) begin
      if ($urandom_range(299) == 0) do_reset();
      else drive(mk($urandom_range(3), $urandom_range(3), $urandom_range(3),
                    $urandom_range(1) == 1, $urandom_range(5) == 0, $urandom_range(4) == 0,
                    $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0));
    end
    @(posedge sysclk);
    @(negedge sysclk); #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum mem_ready wait cycles (BUSY state) before abort; range 1..255.
REQ-002 sysclk  in  1  single clock, all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 ID_rs, ID_rt  in  5 each  source registers of instruction in ID.
REQ-005 EX_MemRead  in  1  instruction in EX is a load.
REQ-006 EX_Write_Register  in  5  destination of instruction in EX.
REQ-007 EX_branch_taken  in  1  branch resolved taken in EX.
REQ-008 ID_jump  in  1  jump decoded in ID.
REQ-009 MEM_MemRead, MEM_MemWrite  in  1 each  memory op in MEM.
REQ-010 mem_ready  in  1  data memory completion strobe.
REQ-011 mem_req  out  1  data memory access request.
REQ-012 pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold PC / stage register.
REQ-013 ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble (all-zero controls) into stage register.
REQ-014 mem_err  out  1  sticky memory timeout flag.
REQ-015 stall_cycles  out  16  saturating count of memory-stall cycles.

Function
REQ-016 mem_op = MEM_MemRead | MEM_MemWrite; FSM states IDLE, BUSY.
REQ-017 IDLE: mem_op=1 -> BUSY next cycle, wait counter cleared; mem_ready ignored in IDLE.
REQ-018 BUSY: mem_ready=1 -> IDLE next cycle; else wait counter increments; counter reaching TIMEOUT -> IDLE, mem_err set.
REQ-019 mem_req = mem_op in IDLE, 1 in BUSY (held until completion or timeout).
REQ-020 mem_stall = mem_op in IDLE, or BUSY with mem_ready=0 and counter < TIMEOUT; completion/timeout cycle is not stalled.
REQ-021 mem_stall=1: pc_stall, ifid_stall, idex_stall, exmem_stall = 1; memwb_flush = 1; ifid_flush = idex_flush = 0.
REQ-022 Every memory op therefore costs at least 1 stall cycle (IDLE detect); with mem_ready on first BUSY cycle exactly 1.
REQ-023 load_use = EX_MemRead & EX_Write_Register != 0 & (EX_Write_Register == ID_rs | EX_Write_Register == ID_rt).
REQ-024 No mem_stall, EX_branch_taken=1: ifid_flush = idex_flush = 1, no stalls (branch overrides load_use and ID_jump).
REQ-025 No mem_stall, no branch, load_use=1: pc_stall = ifid_stall = 1, idex_flush = 1; ID_jump ignored this cycle.
REQ-026 No mem_stall, no branch, no load_use, ID_jump=1: ifid_flush = 1 only.
REQ-027 Otherwise all stall/flush outputs 0.
REQ-028 All stall/flush outputs and mem_req are combinational from FSM state and inputs; zero-cycle latency.
REQ-029 stall_cycles increments by 1 each cycle mem_stall=1; holds at 16'hFFFF.
REQ-030 mem_err cleared only by reset.

Reset
REQ-031 reset asserted: state IDLE, wait counter 0, mem_err 0, stall_cycles 0, immediately and independent of sysclk.
REQ-032 Reset during BUSY aborts the access; mem_req drops asynchronously when MEM controls are cleared by the same reset.
REQ-033 First posedge after reset release evaluates normally from IDLE.

Structure
REQ-034 Package pipe_ctrl_pkg holds the state enum (IDLE, BUSY), TIMEOUT default, counter widths.
REQ-035 Sub-module hazard_detect computes load_use combinationally; FSM, counters and priority mux remain in pipe_ctrl.

Verification
REQ-036 Load-use: EX_MemRead=1, EX_Write_Register=8, ID_rs=8 -> pc_stall=ifid_stall=idex_flush=1; with EX_Write_Register=0 -> all 0.
REQ-037 Branch vs load-use: EX_branch_taken=1 with load_use=1 -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-038 Load, mem_ready after 3 BUSY cycles -> mem_stall 4 cycles, memwb_flush 4 cycles, stall_cycles=4, back to IDLE.
REQ-039 Back-to-back store then load in MEM, mem_ready on first BUSY cycle -> 1 stall cycle each, mem_req continuous, stall_cycles=2.
REQ-040 TIMEOUT=4, mem_ready never -> stall released after 5 stall cycles, mem_err=1 sticky until reset.
REQ-041 Reset mid-BUSY, then release -> state IDLE, stall_cycles=0, mem_err=0, no stall with MEM controls 0.
